// File: rtl/fp32_stage_mul_finalize_pkg.sv
// Shared FP32 types and constants for the multiplier finalize path.
// The stage-1 register struct carries one normalized, not-yet-rounded beat.
package fp32_stage_mul_finalize_pkg;
   typedef logic [31:0] word_t;

   localparam int         FP32_EXP_BIAS = 127;
   localparam logic [7:0] FP32_EXP_MAX  = 8'hFF;
   localparam word_t      FP32_QNAN     = 32'h7FC00000;

   typedef struct packed {
      logic is_nan;
      logic is_inf;
      logic is_zero;
   } fp32_flags_t;

   // exp_s is a two's-complement 11-bit exponent; reinterpret with $signed.
   typedef struct packed {
      logic        sign;
      logic [10:0] exp_s;
      logic [22:0] mant;
      logic        guard;
      logic        sticky;
      fp32_flags_t flags;
   } fp32_norm_t;
endpackage

// File: rtl/fp32_stage_mul_finalize_if.sv
// Input beat and output result handshake bundle of the multiplier finalize stage.
// slave is the stage side, master is the producer/consumer side.
interface fp32_stage_mul_finalize_if;
   logic        valid_i;
   logic        ready_o;
   logic [47:0] product;
   logic [9:0]  exponent_sum;
   logic        sign;
   logic        is_zero;
   logic        is_inf;
   logic        is_nan;
   logic [31:0] result;
   logic        valid_o;
   logic        ready_i;

   modport slave (
      input  valid_i, product, exponent_sum, sign, is_zero, is_inf, is_nan, ready_i,
      output ready_o, result, valid_o
   );

   modport master (
      output valid_i, product, exponent_sum, sign, is_zero, is_inf, is_nan, ready_i,
      input  ready_o, result, valid_o
   );
endinterface

// File: rtl/fp32_stage_mul_finalize_round_rne.sv
// Combinational round-to-nearest-even of a 23-bit mantissa with guard/sticky; a
// mantissa carry wraps the fraction to zero and bumps the exponent.
module fp32_round_rne #(
   parameter bit ROUND_RNE = 1'b1
) (
   input  logic [22:0]        mant,
   input  logic               guard,
   input  logic               sticky,
   input  logic signed [10:0] exp_s,
   output logic [22:0]        mant_r,
   output logic signed [10:0] exp_final
);
   logic round_up;
   logic carry;

   assign round_up       = ROUND_RNE && guard && (sticky || mant[0]);
   assign {carry, mant_r} = {1'b0, mant} + {23'd0, round_up};
   assign exp_final      = exp_s + $signed({10'd0, carry});
endmodule

// File: rtl/fp32_stage_mul_finalize.sv
// FP32 multiply finalize: normalize, round, rebias, pack; 2-cycle valid/ready pipeline,
// 1 beat/cycle, both stages hold under ready_i backpressure and ready_o drops when full.
module fp32_stage_mul_finalize
   import fp32_stage_mul_finalize_pkg::*;
#(
   parameter int EXP_BIAS  = FP32_EXP_BIAS,
   parameter bit ROUND_RNE = 1'b1
) (
   input logic clk,
   input logic rst,
   fp32_stage_mul_finalize_if.slave bus
);
   fp32_norm_t         s1;
   fp32_norm_t         norm_d;
   logic               s1_valid;
   logic               s1_en;
   logic               s2_en;
   logic               valid_q;
   word_t              result_q;
   word_t              pack_d;
   logic [22:0]        mant_r;
   logic signed [10:0] exp_final;

   assign s2_en       = !valid_q || bus.ready_i;
   assign s1_en       = !s1_valid || s2_en;
   assign bus.ready_o = s1_en;
   assign bus.valid_o = valid_q;
   assign bus.result  = result_q;

   // Product of two 1.x significands lies in [1,4); bit 47 set means a one-place shift.
   always_comb begin
      norm_d               = '0;
      norm_d.sign          = bus.sign;
      norm_d.flags.is_nan  = bus.is_nan;
      norm_d.flags.is_inf  = bus.is_inf;
      norm_d.flags.is_zero = bus.is_zero;
      norm_d.exp_s         = {1'b0, bus.exponent_sum} - 11'(EXP_BIAS) + {10'd0, bus.product[47]};
      if (bus.product[47]) begin
         norm_d.mant   = bus.product[46:24];
         norm_d.guard  = bus.product[23];
         norm_d.sticky = |bus.product[22:0];
      end else begin
         norm_d.mant   = bus.product[45:23];
         norm_d.guard  = bus.product[22];
         norm_d.sticky = |bus.product[21:0];
      end
   end

   fp32_round_rne #(.ROUND_RNE(ROUND_RNE)) u_round (
      .mant      (s1.mant),
      .guard     (s1.guard),
      .sticky    (s1.sticky),
      .exp_s     ($signed(s1.exp_s)),
      .mant_r    (mant_r),
      .exp_final (exp_final)
   );

   always_comb begin
      pack_d = '0;
      if (s1.flags.is_nan)
         pack_d = FP32_QNAN;
      else if (s1.flags.is_inf)
         pack_d = {s1.sign, FP32_EXP_MAX, 23'd0};
      else if (s1.flags.is_zero)
         pack_d = {s1.sign, 31'd0};
      else if (exp_final >= 11'sd255)
         pack_d = {s1.sign, FP32_EXP_MAX, 23'd0};
      else if (exp_final <= 11'sd0)
         pack_d = {s1.sign, 31'd0};
      else
         pack_d = {s1.sign, exp_final[7:0], mant_r};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1       <= '0;
         s1_valid <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         if (s1_en) begin
            s1       <= norm_d;
            s1_valid <= bus.valid_i;
         end
         if (s2_en) begin
            valid_q  <= s1_valid;
            result_q <= pack_d;
         end
      end
   end
endmodule

// File: tb/tb_fp32_stage_mul_finalize.sv
// Bench for fp32_stage_mul_finalize: directed IEEE cases, backpressure, reset flush and
// random beats scored against an integer-arithmetic multiply-finalize reference.
module tb_fp32_stage_mul_finalize;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];

   fp32_stage_mul_finalize_if bus ();

   fp32_stage_mul_finalize dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst && bus.valid_o === 1'b1 && bus.ready_i === 1'b1)
         got_q.push_back(bus.result);

   // Reference: exact integer rounding of the significand product to 24 bits.
   function automatic logic [31:0] ref_mul(input logic [47:0] p, input int es,
                                           input logic s, input logic z,
                                           input logic inf, input logic nan);
      longint q, rem, half, pl;
      int     sh, e;
      logic [63:0] qb;
      logic [31:0] ev;
      if (nan) return 32'h7FC00000;
      if (inf) return {s, 8'hFF, 23'h0};
      if (z)   return {s, 31'h0};
      sh   = p[47] ? 24 : 23;
      pl   = longint'({16'd0, p});
      q    = pl >>> sh;
      rem  = pl - (q <<< sh);
      half = 64'sd1 <<< (sh - 1);
      e    = es - 127 + (sh - 23);
      qb   = q;
      if (rem > half || (rem == half && qb[0])) q = q + 1;
      if (q >= (64'sd1 <<< 24)) begin
         q = q >>> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0)   return {s, 31'h0};
      qb = q;
      ev = e;
      return {s, ev[7:0], qb[22:0]};
   endfunction

   task automatic push(input logic [47:0] p, input logic [9:0] es, input logic s,
                       input logic z, input logic inf, input logic nan);
      bit ok = 0;
      bus.valid_i = 1'b1;
      bus.product = p;
      bus.exponent_sum = es;
      bus.sign = s;
      bus.is_zero = z;
      bus.is_inf = inf;
      bus.is_nan = nan;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge clk);
         ok = bus.ready_o;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL push_timeout: ready_o stuck low, required 1");
      end else begin
         exp_q.push_back(ref_mul(p, int'(es), s, z, inf, nan));
      end
      bus.valid_i = 1'b0;
   endtask

   task automatic wait_outputs(input int n, output bit ok);
      ok = 0;
      for (int k = 0; k < 300; k++) begin
         if (got_q.size() >= n) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid_o: got %b required 0", bus.valid_o); end
      vectors++;
      if (bus.result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h required 00000000", bus.result); end
      vectors++;
      if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready_o: got %b required 1", bus.ready_o); end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_latency;
      logic v0, v1;
      logic [31:0] r1;
      got_q.delete();
      exp_q.delete();
      push(48'h600000000000, 10'd255, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      v0 = bus.valid_o;
      @(negedge clk);
      v1 = bus.valid_o;
      r1 = bus.result;
      vectors++;
      if (v0 !== 1'b0) begin miscompares++; $display("FAIL latency_early: valid_o got %b required 0 one cycle after accept", v0); end
      vectors++;
      if (v1 !== 1'b1) begin miscompares++; $display("FAIL latency_valid: valid_o got %b required 1", v1); end
      vectors++;
      if (r1 !== 32'h40400000) begin miscompares++; $display("FAIL mul_3p0: got %h required 40400000", r1); end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed;
      logic [31:0] req[8] = '{32'h40100000, 32'h40000000, 32'h3FFFFFFE, 32'hFF800000,
                              32'h80000000, 32'h7FC00000, 32'h7F800000, 32'h80000000};
      bit ok;
      got_q.delete();
      exp_q.delete();
      push(48'h900000000000, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0);
      push(48'h7FFFFFC00000, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0);
      push(48'h7FFFFF400000, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0);
      push(48'h400000000000, 10'd400, 1'b1, 1'b0, 1'b0, 1'b0);
      push(48'h400000000000, 10'd100, 1'b1, 1'b0, 1'b0, 1'b0);
      push(48'h400000000000, 10'd254, 1'b1, 1'b0, 1'b1, 1'b1);
      push(48'h400000000000, 10'd254, 1'b0, 1'b0, 1'b1, 1'b0);
      push(48'h7FFFFFC00000, 10'd300, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_outputs(8, ok);
      vectors++;
      if (!ok || got_q.size() != 8) begin
         miscompares++;
         $display("FAIL directed_count: got %0d results required 8", got_q.size());
      end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== req[i]) begin
            miscompares++;
            $display("FAIL directed_%0d: got %h required %h", i, got_q[i], req[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      bit saw_drop = 0;
      got_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 4; i++)
               push({2'b01, 46'($urandom) ^ {14'd0, 32'(i)}}, 10'(200 + i), i[0], 1'b0, 1'b0, 1'b0);
         end
         begin
            repeat (2) @(posedge clk);
            #1 bus.ready_i = 1'b0;
            repeat (4) @(posedge clk);
            #1 bus.ready_i = 1'b1;
         end
         begin
            logic        prev_stall = 1'b0;
            logic [31:0] prev_res = '0;
            for (int c = 0; c < 12; c++) begin
               @(negedge clk);
               if (bus.ready_o === 1'b0) saw_drop = 1;
               if (prev_stall) begin
                  vectors++;
                  if (bus.result !== prev_res || bus.valid_o !== 1'b1) begin
                     miscompares++;
                     $display("FAIL stall_hold: result %h valid %b required %h valid 1", bus.result, bus.valid_o, prev_res);
                  end
               end
               prev_stall = bus.valid_o && !bus.ready_i;
               prev_res   = bus.result;
            end
         end
      join
      vectors++;
      if (!saw_drop) begin miscompares++; $display("FAIL ready_o_drop: ready_o got 1 throughout stall, required 0 once full"); end
      wait_outputs(4, ok);
      vectors++;
      if (!ok || got_q.size() != 4) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d results required 4", got_q.size());
      end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL b2b_%0d: got %h required %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_in_flight;
      bit seen = 0;
      got_q.delete();
      exp_q.delete();
      push(48'h600000000000, 10'd255, 1'b0, 1'b0, 1'b0, 1'b0);
      push(48'h900000000000, 10'd254, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_valid_o: got %b required 0", bus.valid_o); end
      vectors++;
      if (bus.result !== 32'h0) begin miscompares++; $display("FAIL flush_result: got %h required 00000000", bus.result); end
      vectors++;
      if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL flush_ready_o: got %b required 1", bus.ready_o); end
      rst = 1'b0;
      got_q.delete();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.valid_o !== 1'b0) seen = 1;
      end
      vectors++;
      if (seen || got_q.size() != 0) begin
         miscompares++;
         $display("FAIL flush_stale: got %0d stale results required 0", got_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random;
      bit ok;
      bit done = 0;
      got_q.delete();
      exp_q.delete();
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic [23:0] ma, mb;
               logic [9:0]  es;
               ma = {1'b1, 23'($urandom)};
               mb = {1'b1, 23'($urandom)};
               if ((i % 8) == 0) mb = 24'h800000;
               es = 10'($urandom_range(0, 7) == 0 ? $urandom_range(0, 510) : $urandom_range(110, 390));
               push(48'(ma) * 48'(mb), es, 1'($urandom), $urandom_range(0, 15) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 bus.ready_i = ($urandom_range(0, 3) != 0);
            end
            bus.ready_i = 1'b1;
         end
      join
      bus.ready_i = 1'b1;
      wait_outputs(40, ok);
      vectors++;
      if (!ok || got_q.size() != 40) begin
         miscompares++;
         $display("FAIL random_count: got %0d results required 40", got_q.size());
      end
      for (int i = 0; i < 40 && i < got_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL random_%0d: got %h required %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      bus.valid_i = 1'b0;
      bus.product = '0;
      bus.exponent_sum = '0;
      bus.sign = 1'b0;
      bus.is_zero = 1'b0;
      bus.is_inf = 1'b0;
      bus.is_nan = 1'b0;
      bus.ready_i = 1'b1;
      test_reset();
      test_latency();
      test_directed();
      test_back_to_back();
      test_reset_in_flight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fp32_stage_mul_finalize.md
Name: fp32_stage_mul_finalize

Overview:
Final stage of the FP32 multiplier pipeline and the output end of the setup stage. It accepts the 48-bit significand product, the doubly-biased exponent sum, the sign and the special-case flags. It normalizes, rounds (round-to-nearest-even), rebiases, handles overflow and underflow, and packs an IEEE-754 word_t. It is a 2-stage valid/ready pipeline that feeds the PE accumulator.

Parameters:
EXP_BIAS, 127, exponent bias subtracted from exponent_sum.
ROUND_RNE, 1, 1 = round-to-nearest-even; 0 = truncate (guard/sticky ignored).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
valid_i  input  1  input beat valid
ready_o  output  1  stage can accept input this cycle
product  input  48  {1,mant_a}*{1,mant_b}, unsigned, binary point after bit 46
exponent_sum  input  10  exp_a+exp_b, unsigned (0..510)
sign  input  1  sign_a^sign_b
is_zero  input  1  either operand zero/denormal
is_inf  input  1  either operand infinite, neither NaN
is_nan  input  1  either operand NaN, or inf*zero
result  output  32  packed word_t {sign,exponent[7:0],mantissa[22:0]}
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result

Behaviour:
- Reset (rst high at a posedge): all pipeline registers cleared; valid_o=0, result=0, ready_o=1 in the following cycle. Reset mid-operation drops in-flight beats with no partial output.
- Handshake: a transfer occurs when valid && ready on the same edge. s2_en = !valid_o || ready_i; s1_en = !s1_valid || s2_en; ready_o = s1_en (combinational). Both stages hold while stalled. result and valid_o stay stable while valid_o && !ready_i.
- Latency: 2 cycles from input acceptance to valid_o with no stall. Throughput: 1 per cycle.
- Stage 1 (normalize), loads on s1_en:
  - n = product[47].
  - If n=1: mant = product[46:24], guard = product[23], sticky = |product[22:0].
  - If n=0: mant = product[45:23], guard = product[22], sticky = |product[21:0].
  - exp_s (11-bit signed) = exponent_sum - EXP_BIAS + n.
  - sign and flags are registered; s1_valid = valid_i.
- Stage 2 (round/pack), loads on s2_en:
  - round_up = ROUND_RNE && guard && (sticky || mant[0]).
  - {carry, mant_r} = mant + round_up. If carry=1, mant_r = 0 and exp_s+1.
- Priority when packing:
  1. is_nan → 0x7FC00000 (sign forced 0).
  2. is_inf → {sign,8'hFF,0}.
  3. is_zero → {sign,0,0}.
  4. exp_final >= 255 → {sign,8'hFF,0} (overflow to infinity).
  5. exp_final <= 0 → {sign,0,0} (flush to zero; no denormal output).
  6. Otherwise → {sign,exp_final[7:0],mant_r}.
- Simultaneous input and output transfer in the same cycle is legal; there are no bubbles.

Decomposition:
- Shared package (systolic_array_pkg.svh): word_t (already there), FP32_EXP_BIAS=127, FP32_EXP_MAX=8'hFF, FP32_QNAN=32'h7FC00000, and a struct fp32_norm_t {sign, exp_s[10:0], mant[22:0], guard, sticky, flags} used as the stage-1 register.
- One sub-module: fp32_round_rne (combinational). Inputs are mant, guard, sticky and exp_s; outputs are mant_r and exp_final. It is reused by the future adder finalize stage.

Test Plan:
- product=0x600000000000, exponent_sum=255, sign=0 → result 0x40400000 (1.5*2.0=3.0), valid_o exactly 2 cycles after acceptance.
- product=0x900000000000, exponent_sum=254 → 0x40100000 (1.5*1.5=2.25, n=1 path).
- Rounding:
  - product=0x7FFFFFC00000, exponent_sum=254 → 0x40000000 (mantissa carry bumps exponent).
  - product=0x7FFFFF400000, exponent_sum=254 → 0x3FFFFFFE (tie with even lsb, no round).
- exponent_sum=400, product=0x400000000000, sign=1 → 0xFF800000. exponent_sum=100 → 0x80000000. is_nan=1 → 0x7FC00000. is_inf=1, sign=0 → 0x7F800000.
- Backpressure: 4 back-to-back beats with ready_i low cycles 3–6 → ready_o drops after both stages fill, result held stable, all 4 results emitted in order with none lost or duplicated.
- Reset asserted while 2 beats are in flight → next cycle valid_o=0, result=0, ready_o=1; no stale output after release.
